// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle MIPS main FSM (master) and the datapath (slave).
// The datapath side supplies the opcode and memory handshake; the FSM drives every select and enable.
interface multicycle_control_if;
    logic [5:0] op;
    logic       mem_ready;
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       irwrite;
    logic       regdst;
    logic       regwrite;
    logic       ULAsrcA;
    logic [1:0] ULAsrcB;
    logic [1:0] ULAop;
    logic [1:0] pcsource;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  op, mem_ready,
        output pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite,
               regdst, regwrite, ULAsrcA, ULAsrcB, ULAop, pcsource, illegal_op, state
    );

    modport slave (
        output op, mem_ready,
        input  pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite,
               regdst, regwrite, ULAsrcA, ULAsrcB, ULAop, pcsource, illegal_op, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath: sequences fetch/decode/execute/memory/writeback
// for R-format, LW, SW, BEQ, ADDI and J, stalling on mem_ready during each memory access.
module multicycle_control (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_R_FORMAT = 6'b000000;
    localparam logic [5:0] OP_LW       = 6'b100011;
    localparam logic [5:0] OP_SW       = 6'b101011;
    localparam logic [5:0] OP_BEQ      = 6'b000100;
    localparam logic [5:0] OP_ADDI     = 6'b001000;
    localparam logic [5:0] OP_J        = 6'b000010;

    state_t     state_q, state_d;
    logic       pcwrite, pcwritecond, iord, memread, memwrite, memtoreg;
    logic       irwrite, regdst, regwrite, ula_src_a, illegal_op;
    logic [1:0] ula_src_b, ula_op, pcsource;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        state_d     = state_q;
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        memtoreg    = 1'b0;
        irwrite     = 1'b0;
        regdst      = 1'b0;
        regwrite    = 1'b0;
        ula_src_a   = 1'b0;
        ula_src_b   = 2'b00;
        ula_op      = 2'b00;
        pcsource    = 2'b00;
        illegal_op  = 1'b0;

        case (state_q)
            FETCH: begin
                memread   = 1'b1;
                ula_src_b = 2'b01;
                // PC+4 and IR load commit only on the cycle the read completes.
                irwrite   = bus.mem_ready;
                pcwrite   = bus.mem_ready;
                if (bus.mem_ready) state_d = DECODE;
            end
            DECODE: begin
                ula_src_b = 2'b11;
                case (bus.op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R_FORMAT:  state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default: begin
                        state_d    = FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ula_src_a = 1'b1;
                ula_src_b = 2'b10;
                state_d   = (bus.op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
                if (bus.mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                state_d  = FETCH;
            end
            MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
                if (bus.mem_ready) state_d = FETCH;
            end
            EXECUTE: begin
                ula_src_a = 1'b1;
                ula_op    = 2'b10;
                state_d   = ALUWB;
            end
            ALUWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                state_d  = FETCH;
            end
            BRANCH: begin
                ula_src_a   = 1'b1;
                ula_op      = 2'b01;
                pcwritecond = 1'b1;
                pcsource    = 2'b01;
                state_d     = FETCH;
            end
            ADDIEX: begin
                ula_src_a = 1'b1;
                ula_src_b = 2'b10;
                state_d   = ADDIWB;
            end
            ADDIWB: begin
                regwrite = 1'b1;
                state_d  = FETCH;
            end
            JUMP: begin
                pcwrite  = 1'b1;
                pcsource = 2'b10;
                state_d  = FETCH;
            end
            default: state_d = FETCH;
        endcase

        // Reset silences every enable so an aborted instruction leaves no side effect.
        if (reset) begin
            pcwrite     = 1'b0;
            pcwritecond = 1'b0;
            iord        = 1'b0;
            memread     = 1'b0;
            memwrite    = 1'b0;
            memtoreg    = 1'b0;
            irwrite     = 1'b0;
            regdst      = 1'b0;
            regwrite    = 1'b0;
            ula_src_a   = 1'b0;
            ula_src_b   = 2'b00;
            ula_op      = 2'b00;
            pcsource    = 2'b00;
            illegal_op  = 1'b0;
        end
    end

    assign bus.pcwrite     = pcwrite;
    assign bus.pcwritecond = pcwritecond;
    assign bus.iord        = iord;
    assign bus.memread     = memread;
    assign bus.memwrite    = memwrite;
    assign bus.memtoreg    = memtoreg;
    assign bus.irwrite     = irwrite;
    assign bus.regdst      = regdst;
    assign bus.regwrite    = regwrite;
    assign bus.ULAsrcA     = ula_src_a;
    assign bus.ULAsrcB     = ula_src_b;
    assign bus.ULAop       = ula_op;
    assign bus.pcsource    = pcsource;
    assign bus.illegal_op  = illegal_op;
    assign bus.state       = reset ? 4'd0 : state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks every instruction class, memory stalls,
// an illegal opcode and a mid-instruction reset, checking all outputs every cycle.
module tb_multicycle_control;
    typedef struct packed {
        logic [3:0] state;
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       irwrite;
        logic       regdst;
        logic       regwrite;
        logic       src_a;
        logic [1:0] src_b;
        logic [1:0] ula_op;
        logic [1:0] pcsource;
        logic       illegal_op;
    } ctl_t;

    localparam logic [5:0] R_OP = 6'b000000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] J    = 6'b000010;
    localparam logic [5:0] BAD  = 6'b111111;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic ctl_t observed();
        ctl_t o;
        o = '{state: bus.state, pcwrite: bus.pcwrite, pcwritecond: bus.pcwritecond,
              iord: bus.iord, memread: bus.memread, memwrite: bus.memwrite,
              memtoreg: bus.memtoreg, irwrite: bus.irwrite, regdst: bus.regdst,
              regwrite: bus.regwrite, src_a: bus.ULAsrcA, src_b: bus.ULAsrcB,
              ula_op: bus.ULAop, pcsource: bus.pcsource, illegal_op: bus.illegal_op};
        return o;
    endfunction

    // Expected outputs per state, written straight from the state table.
    function automatic ctl_t expected(input logic [3:0] st, input logic mr, input logic ill);
        ctl_t e;
        e = '0;
        e.state = st;
        case (st)
            4'd0:  begin e.memread = 1'b1; e.src_b = 2'b01; e.irwrite = mr; e.pcwrite = mr; end
            4'd1:  begin e.src_b = 2'b11; e.illegal_op = ill; end
            4'd2:  begin e.src_a = 1'b1; e.src_b = 2'b10; end
            4'd3:  begin e.memread = 1'b1; e.iord = 1'b1; end
            4'd4:  begin e.regwrite = 1'b1; e.memtoreg = 1'b1; end
            4'd5:  begin e.memwrite = 1'b1; e.iord = 1'b1; end
            4'd6:  begin e.src_a = 1'b1; e.ula_op = 2'b10; end
            4'd7:  begin e.regwrite = 1'b1; e.regdst = 1'b1; end
            4'd8:  begin e.src_a = 1'b1; e.ula_op = 2'b01; e.pcwritecond = 1'b1; e.pcsource = 2'b01; end
            4'd9:  begin e.src_a = 1'b1; e.src_b = 2'b10; end
            4'd10: begin e.regwrite = 1'b1; end
            4'd11: begin e.pcwrite = 1'b1; e.pcsource = 2'b10; end
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic check(input string tag, input ctl_t exp_v);
        ctl_t obs;
        obs = observed();
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Drive inputs, check outputs mid-cycle, then advance one clock.
    task automatic step(input string tag, input logic [5:0] op, input logic mr,
                        input logic [3:0] st, input logic ill);
        bus.op        = op;
        bus.mem_ready = mr;
        #1;
        check(tag, expected(st, mr, ill));
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset         = 1'b1;
        bus.op        = R_OP;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_outputs_zero", '0);
        reset = 1'b0;

        // R-format
        step("r_fetch",   R_OP, 1'b1, 4'd0, 1'b0);
        step("r_decode",  R_OP, 1'b1, 4'd1, 1'b0);
        step("r_execute", BAD,  1'b0, 4'd6, 1'b0);
        step("r_aluwb",   BAD,  1'b0, 4'd7, 1'b0);

        // LW with two wait cycles in MEMRD
        step("lw_fetch",  LW,   1'b1, 4'd0, 1'b0);
        step("lw_decode", LW,   1'b1, 4'd1, 1'b0);
        step("lw_memadr", LW,   1'b1, 4'd2, 1'b0);
        step("lw_memrd0", SW,   1'b0, 4'd3, 1'b0);
        step("lw_memrd1", SW,   1'b0, 4'd3, 1'b0);
        step("lw_memrd2", SW,   1'b1, 4'd3, 1'b0);
        step("lw_memwb",  BAD,  1'b0, 4'd4, 1'b0);

        // SW with one wait cycle in MEMWR
        step("sw_fetch",  SW,   1'b1, 4'd0, 1'b0);
        step("sw_decode", SW,   1'b1, 4'd1, 1'b0);
        step("sw_memadr", SW,   1'b1, 4'd2, 1'b0);
        step("sw_memwr0", LW,   1'b0, 4'd5, 1'b0);
        step("sw_memwr1", LW,   1'b1, 4'd5, 1'b0);

        // BEQ
        step("beq_fetch",  BEQ, 1'b1, 4'd0, 1'b0);
        step("beq_decode", BEQ, 1'b1, 4'd1, 1'b0);
        step("beq_branch", R_OP, 1'b0, 4'd8, 1'b0);

        // J
        step("j_fetch",  J,    1'b1, 4'd0, 1'b0);
        step("j_decode", J,    1'b1, 4'd1, 1'b0);
        step("j_jump",   LW,   1'b0, 4'd11, 1'b0);

        // FETCH stalled three cycles, then ADDI completes
        step("fetch_wait0", ADDI, 1'b0, 4'd0, 1'b0);
        step("fetch_wait1", ADDI, 1'b0, 4'd0, 1'b0);
        step("fetch_wait2", ADDI, 1'b0, 4'd0, 1'b0);
        step("fetch_done",  ADDI, 1'b1, 4'd0, 1'b0);
        step("addi_decode", ADDI, 1'b1, 4'd1, 1'b0);
        step("addi_ex",     BAD,  1'b1, 4'd9, 1'b0);
        step("addi_wb",     BAD,  1'b1, 4'd10, 1'b0);

        // Illegal opcode
        step("ill_fetch",  BAD, 1'b1, 4'd0, 1'b0);
        step("ill_decode", BAD, 1'b1, 4'd1, 1'b1);

        // ADDI aborted by reset in ADDIEX
        step("abort_fetch",  ADDI, 1'b1, 4'd0, 1'b0);
        step("abort_decode", ADDI, 1'b1, 4'd1, 1'b0);
        bus.op        = ADDI;
        bus.mem_ready = 1'b1;
        #1;
        check("abort_addiex_before_reset", expected(4'd9, 1'b1, 1'b0));
        reset = 1'b1;
        #1;
        check("abort_reset_outputs_zero", '0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        // Must be back in FETCH, not ADDIWB: no regwrite pulse from the aborted ADDI.
        step("post_reset_fetch", R_OP, 1'b1, 4'd0, 1'b0);
        step("post_reset_decode", R_OP, 1'b1, 4'd1, 1'b0);
        step("post_reset_execute", R_OP, 1'b1, 4'd6, 1'b0);
        step("post_reset_aluwb", R_OP, 1'b1, 4'd7, 1'b0);
        step("post_reset_next_fetch", R_OP, 1'b0, 4'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
